// File: rtl/snake_pkg.sv
// Shared encodings for the snake body engine: movement directions, game
// states, and the helper that names the reverse of a direction.
package snake_pkg;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] UP    = 3'd1;
  localparam logic [2:0] DOWN  = 3'd2;
  localparam logic [2:0] LEFT  = 3'd3;
  localparam logic [2:0] RIGHT = 3'd4;

  localparam logic [1:0] PLAY      = 2'b01;
  localparam logic [1:0] GAME_OVER = 2'b11;

  // Direction that would send the snake back into its own neck.
  function automatic logic [2:0] opposite_dir(input logic [2:0] dir);
    case (dir)
      UP:      opposite_dir = DOWN;
      DOWN:    opposite_dir = UP;
      LEFT:    opposite_dir = RIGHT;
      RIGHT:   opposite_dir = LEFT;
      default: opposite_dir = IDLE;
    endcase
  endfunction

endpackage

// File: rtl/snake_cell_hit.sv
// Tests one pixel against one square cell. hit covers the full cell;
// inset_hit drops a one-pixel border on every side so adjacent body cells
// render with a visible gap. All compares run one bit wider than the
// coordinates so cell_x + CELL cannot wrap.
module snake_cell_hit
  import snake_pkg::*;
#(
  parameter int CELL = 10,
  parameter int BIT  = 10
) (
  input  logic [BIT-1:0] x_pos,
  input  logic [BIT-1:0] y_pos,
  input  logic [BIT-1:0] cell_x,
  input  logic [BIT-1:0] cell_y,
  output logic           hit,
  output logic           inset_hit
);

  localparam logic [BIT:0] SIZE = (BIT+1)'(CELL);
  localparam logic [BIT:0] ONE  = (BIT+1)'(1);

  logic [BIT:0] px, py, x_lo, y_lo, x_hi, y_hi, x_lo_in, y_lo_in, x_hi_in, y_hi_in;

  assign px      = {1'b0, x_pos};
  assign py      = {1'b0, y_pos};
  assign x_lo    = {1'b0, cell_x};
  assign y_lo    = {1'b0, cell_y};
  assign x_hi    = x_lo + SIZE;
  assign y_hi    = y_lo + SIZE;
  assign x_lo_in = x_lo + ONE;
  assign y_lo_in = y_lo + ONE;
  assign x_hi_in = x_hi - ONE;
  assign y_hi_in = y_hi - ONE;

  assign hit       = (px >= x_lo) && (px < x_hi) && (py >= y_lo) && (py < y_hi);
  assign inset_hit = (px >= x_lo_in) && (px < x_hi_in) && (py >= y_lo_in) && (py < y_hi_in);

endmodule

// File: rtl/snake_body_engine.sv
// Snake movement and body store. Keeps the head and up to MAX_BODY trailing
// segments, steps one cell per game tick in the latched heading, grows on
// apple events, flags wall and self collisions, and produces registered
// per-pixel head/body hit flags for the renderer.
module snake_body_engine
  import snake_pkg::*;
#(
  parameter int CELL     = 10,
  parameter int BIT      = 10,
  parameter int MAX_BODY = 16,
  parameter int LEN_W    = 5,
  parameter int X_START  = 320,
  parameter int Y_START  = 240,
  parameter int X_LIMIT  = 640,
  parameter int Y_LIMIT  = 480
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             update,
  input  logic [2:0]       direction,
  input  logic [1:0]       game_state,
  input  logic             grow,
  input  logic [BIT-1:0]   x_pos,
  input  logic [BIT-1:0]   y_pos,
  output logic             head_active,
  output logic             body_active,
  output logic             self_hit,
  output logic             wall_hit,
  output logic [LEN_W-1:0] length,
  output logic [BIT-1:0]   head_x,
  output logic [BIT-1:0]   head_y
);

  localparam logic [BIT:0]     STEP    = (BIT+1)'(CELL);
  localparam logic [BIT:0]     X_MAX   = (BIT+1)'(X_LIMIT - CELL);
  localparam logic [BIT:0]     Y_MAX   = (BIT+1)'(Y_LIMIT - CELL);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_BODY);

  logic [2:0]       heading, heading_nxt;
  logic             grow_pend, pend_eff;
  logic [BIT-1:0]   seg_x [MAX_BODY];
  logic [BIT-1:0]   seg_y [MAX_BODY];
  logic [BIT:0]     next_x, next_y;
  logic             move_req, blocked, move_ok;
  logic [LEN_W-1:0] len_nxt;
  logic [MAX_BODY-1:0] self_match, seg_live;
  logic               restart;

  logic [BIT-1:0]   cell_x [MAX_BODY+1];
  logic [BIT-1:0]   cell_y [MAX_BODY+1];
  logic [MAX_BODY:0] cell_hit, cell_inset;

  // The head only needs the full-cell test and the body only the inset test;
  // the other halves are collected here so they are visibly intentional.
  logic               unused_head_inset;
  logic [MAX_BODY-1:0] unused_body_full;
  assign unused_head_inset = cell_inset[0];
  assign unused_body_full  = cell_hit[MAX_BODY:1];

  // GAME_OVER holds the engine in its restart state just like reset.
  assign restart  = reset || (game_state == GAME_OVER);
  assign pend_eff = grow_pend || grow;
  assign move_req = update && (game_state == PLAY) && (heading != IDLE);
  assign move_ok  = move_req && !blocked;
  assign len_nxt  = (pend_eff && (length < LEN_MAX)) ? length + LEN_W'(1) : length;

  // Accept a new heading unless it is idle or would reverse a snake with a body.
  always_comb begin
    heading_nxt = heading;
    if ((direction != IDLE) && (direction <= RIGHT) &&
        !((length != '0) && (direction == opposite_dir(heading))))
      heading_nxt = direction;
  end

  // Candidate head one cell ahead; a subtraction below zero wraps high and
  // therefore lands beyond the limit, so one compare covers both edges.
  always_comb begin
    next_x = {1'b0, head_x};
    next_y = {1'b0, head_y};
    case (heading)
      UP:      next_y = {1'b0, head_y} - STEP;
      DOWN:    next_y = {1'b0, head_y} + STEP;
      LEFT:    next_x = {1'b0, head_x} - STEP;
      RIGHT:   next_x = {1'b0, head_x} + STEP;
      default: ;
    endcase
    blocked = (next_x > X_MAX) || (next_y > Y_MAX);
  end

  // Self collision against the body as it will look after the shift, so the
  // tail cell being vacated on this move never counts.
  always_comb begin
    self_match    = '0;
    self_match[0] = ({1'b0, head_x} == next_x) && ({1'b0, head_y} == next_y) && (len_nxt != '0);
    for (int i = 1; i < MAX_BODY; i++) begin
      if ((i < int'(len_nxt)) && ({1'b0, seg_x[i-1]} == next_x) && ({1'b0, seg_y[i-1]} == next_y))
        self_match[i] = 1'b1;
    end
  end

  // Head, heading, growth bookkeeping and collision pulses.
  always_ff @(posedge clk) begin
    if (restart) begin
      head_x    <= BIT'(X_START);
      head_y    <= BIT'(Y_START);
      length    <= '0;
      heading   <= IDLE;
      grow_pend <= 1'b0;
      wall_hit  <= 1'b0;
      self_hit  <= 1'b0;
    end else begin
      heading  <= heading_nxt;
      wall_hit <= move_req && blocked;
      self_hit <= move_ok && (|self_match);
      if (move_ok) begin
        head_x    <= next_x[BIT-1:0];
        head_y    <= next_y[BIT-1:0];
        length    <= len_nxt;
        grow_pend <= 1'b0;
      end else begin
        grow_pend <= pend_eff;
      end
    end
  end

  // Body shift register: the old head becomes segment 0 on every move.
  always_ff @(posedge clk) begin
    if (restart) begin
      for (int i = 0; i < MAX_BODY; i++) begin
        seg_x[i] <= BIT'(X_LIMIT);
        seg_y[i] <= BIT'(Y_LIMIT);
      end
    end else if (move_ok) begin
      for (int i = MAX_BODY - 1; i > 0; i--) begin
        seg_x[i] <= seg_x[i-1];
        seg_y[i] <= seg_y[i-1];
      end
      seg_x[0] <= head_x;
      seg_y[0] <= head_y;
    end
  end

  // Cell list for the pixel compare: entry 0 is the head, then the body.
  always_comb begin
    cell_x[0] = head_x;
    cell_y[0] = head_y;
    for (int i = 0; i < MAX_BODY; i++) begin
      cell_x[i+1] = seg_x[i];
      cell_y[i+1] = seg_y[i];
      seg_live[i] = (i < int'(length));
    end
  end

  for (genvar g = 0; g <= MAX_BODY; g++) begin : g_cell
    snake_cell_hit #(
      .CELL (CELL),
      .BIT  (BIT)
    ) u_cell_hit (
      .x_pos     (x_pos),
      .y_pos     (y_pos),
      .cell_x    (cell_x[g]),
      .cell_y    (cell_y[g]),
      .hit       (cell_hit[g]),
      .inset_hit (cell_inset[g])
    );
  end

  // Register the pixel hits for the renderer; blank while restarting.
  always_ff @(posedge clk) begin
    if (restart) begin
      head_active <= 1'b0;
      body_active <= 1'b0;
    end else begin
      head_active <= cell_hit[0];
      body_active <= |(cell_inset[MAX_BODY:1] & seg_live);
    end
  end

endmodule

// File: tb/tb_snake_body_engine.sv
// Bench for snake_body_engine: a directed vector table, hand-written corner
// sequences and a randomized run, all compared against a queue-based model
// of the snake that lives in this file.
`timescale 1ns/1ps
module tb_snake_body_engine;
  import snake_pkg::*;

  localparam int CELL = 10;
  localparam int BIT  = 10;
  localparam int MAXB = 16;
  localparam int XL   = 640;
  localparam int YL   = 480;
  localparam int XS   = 320;
  localparam int YS   = 240;
  localparam int PL   = 1;
  localparam int GO   = 3;

  logic           clk = 1'b0;
  logic           reset, update, grow;
  logic [2:0]     direction;
  logic [1:0]     game_state;
  logic [BIT-1:0] x_pos, y_pos;
  logic           head_active, body_active, self_hit, wall_hit;
  logic [4:0]     length;
  logic [BIT-1:0] head_x, head_y;
  logic           head_active4, body_active4, self_hit4, wall_hit4;
  logic [2:0]     length4;
  logic [BIT-1:0] head_x4, head_y4;

  always #5 clk = ~clk;

  snake_body_engine dut (
    .clk(clk), .reset(reset), .update(update), .direction(direction),
    .game_state(game_state), .grow(grow), .x_pos(x_pos), .y_pos(y_pos),
    .head_active(head_active), .body_active(body_active), .self_hit(self_hit),
    .wall_hit(wall_hit), .length(length), .head_x(head_x), .head_y(head_y)
  );

  snake_body_engine #(.MAX_BODY(4), .LEN_W(3)) dut4 (
    .clk(clk), .reset(reset), .update(update), .direction(direction),
    .game_state(game_state), .grow(grow), .x_pos(x_pos), .y_pos(y_pos),
    .head_active(head_active4), .body_active(body_active4), .self_hit(self_hit4),
    .wall_hit(wall_hit4), .length(length4), .head_x(head_x4), .head_y(head_y4)
  );

  int checks = 0;
  int errors = 0;

  typedef struct { int x; int y; } cell_t;
  cell_t body[$];
  int m_hx, m_hy, m_heading;
  bit m_pend, exp_head, exp_body, exp_self, exp_wall;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int opp(input int d);
    case (d)
      1: return 2;
      2: return 1;
      3: return 4;
      4: return 3;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_hx = XS; m_hy = YS; m_heading = 0; m_pend = 0;
    body.delete();
    exp_head = 0; exp_body = 0; exp_self = 0; exp_wall = 0;
  endtask

  // One clock of the game rules, applied to the snake as a list of cells.
  task automatic model_step(input bit rst, input bit upd, input bit grw, input int dir,
                            input int gs, input int px, input int py);
    int nx, ny, nh;
    bit pend, grows;
    if (rst || gs == GO) begin
      model_reset();
      return;
    end
    exp_head = (px >= m_hx) && (px < m_hx + CELL) && (py >= m_hy) && (py < m_hy + CELL);
    exp_body = 0;
    foreach (body[i])
      if (px > body[i].x && px < body[i].x + CELL - 1 && py > body[i].y && py < body[i].y + CELL - 1)
        exp_body = 1;
    nh = m_heading;
    if (dir != 0 && !(body.size() > 0 && dir == opp(m_heading))) nh = dir;
    exp_wall = 0; exp_self = 0;
    pend = m_pend || grw;
    if (upd && gs == PL && m_heading != 0) begin
      nx = m_hx; ny = m_hy;
      case (m_heading)
        1: ny = ny - CELL;
        2: ny = ny + CELL;
        3: nx = nx - CELL;
        default: nx = nx + CELL;
      endcase
      if (nx < 0 || ny < 0 || nx > XL - CELL || ny > YL - CELL) begin
        exp_wall = 1;
        m_pend = pend;
      end else begin
        grows = pend && (body.size() < MAXB);
        body.push_front('{m_hx, m_hy});
        if (!grows) void'(body.pop_back());
        m_hx = nx; m_hy = ny; m_pend = 0;
        foreach (body[i]) if (body[i].x == nx && body[i].y == ny) exp_self = 1;
      end
    end else begin
      m_pend = pend;
    end
    m_heading = nh;
  endtask

  task automatic apply(input bit rst, input bit upd, input bit grw, input int dir,
                       input int gs, input int px, input int py);
    reset = rst; update = upd; grow = grw;
    direction = 3'(dir); game_state = 2'(gs);
    x_pos = BIT'(px); y_pos = BIT'(py);
    @(posedge clk);
    model_step(rst, upd, grw, dir, gs, px % 1024, py % 1024);
    #1;
    check("head_x", head_x, m_hx);
    check("head_y", head_y, m_hy);
    check("length", length, body.size());
    check("head_active", head_active, exp_head);
    check("body_active", body_active, exp_body);
    check("self_hit", self_hit, exp_self);
    check("wall_hit", wall_hit, exp_wall);
    reset = 0; update = 0; grow = 0; direction = 0;
  endtask

  task automatic restart_right();
    apply(1, 0, 0, 0, 0, 0, 0);
    apply(0, 0, 0, RIGHT, PL, 0, 0);
  endtask

  typedef struct {
    bit upd; bit grw; int dir; int px; int py;
    int e_hx; int e_hy; int e_len; bit e_head; bit e_body; bit e_wall;
  } vec_t;

  vec_t tbl[8];

  initial begin
    reset = 1; update = 0; grow = 0; direction = 0; game_state = 0; x_pos = 0; y_pos = 0;
    model_reset();

    // Reset state.
    apply(1, 0, 0, 0, 0, 0, 0);
    check("rst_head_x", head_x, 320);
    check("rst_head_y", head_y, 240);
    check("rst_length", length, 0);
    check("rst_flags", {head_active, body_active, self_hit, wall_hit}, 0);

    // Three RIGHT moves from the start cell, with head pixel probes.
    tbl[0] = '{0, 0, RIGHT, 325, 245, 320, 240, 0, 1, 0, 0};
    tbl[1] = '{1, 0, 0,       0,   0, 330, 240, 0, 0, 0, 0};
    tbl[2] = '{1, 0, 0,     335, 245, 340, 240, 0, 1, 0, 0};
    tbl[3] = '{1, 0, 0,     345, 245, 350, 240, 0, 1, 0, 0};
    tbl[4] = '{0, 0, 0,     355, 245, 350, 240, 0, 1, 0, 0};
    tbl[5] = '{0, 0, 0,     360, 245, 350, 240, 0, 0, 0, 0};
    tbl[6] = '{0, 0, 0,     349, 245, 350, 240, 0, 0, 0, 0};
    tbl[7] = '{0, 0, 0,     355, 250, 350, 240, 0, 0, 0, 0};
    for (int i = 0; i < 8; i++) begin
      apply(0, tbl[i].upd, tbl[i].grw, tbl[i].dir, PL, tbl[i].px, tbl[i].py);
      check($sformatf("tbl%0d_hx", i), head_x, tbl[i].e_hx);
      check($sformatf("tbl%0d_hy", i), head_y, tbl[i].e_hy);
      check($sformatf("tbl%0d_len", i), length, tbl[i].e_len);
      check($sformatf("tbl%0d_head", i), head_active, tbl[i].e_head);
      check($sformatf("tbl%0d_body", i), body_active, tbl[i].e_body);
      check($sformatf("tbl%0d_wall", i), wall_hit, tbl[i].e_wall);
    end

    // Growth: three grow-moves, then probe each body cell.
    restart_right();
    for (int i = 0; i < 3; i++) apply(0, 1, 1, 0, PL, 0, 0);
    check("grow_len", length, 3);
    check("grow_len4", length4, 3);
    apply(0, 0, 0, 0, PL, 345, 245); check("seg0_body", body_active, 1);
    apply(0, 0, 0, 0, PL, 335, 245); check("seg1_body", body_active, 1);
    apply(0, 0, 0, 0, PL, 325, 245); check("seg2_body", body_active, 1);
    apply(0, 0, 0, 0, PL, 340, 245); check("seg0_edge", body_active, 0);
    apply(0, 0, 0, 0, PL, 348, 248); check("seg0_inner", body_active, 1);
    apply(0, 0, 0, 0, PL, 345, 249); check("seg0_bottom", body_active, 0);
    apply(0, 0, 0, 0, PL, 355, 245); check("head_px", head_active, 1);
    check("head_not_body", body_active, 0);

    // Saturation: keep growing well past both body limits.
    for (int i = 0; i < 15; i++) apply(0, 1, 1, 0, PL, 0, 0);
    check("sat_len", length, 16);
    check("sat_len4", length4, 4);
    check("sat_hx4", head_x4, 500);

    // Reversal is refused with a body, allowed without.
    restart_right();
    for (int i = 0; i < 2; i++) apply(0, 1, 1, 0, PL, 0, 0);
    apply(0, 0, 0, LEFT, PL, 0, 0);
    apply(0, 1, 0, 0, PL, 0, 0);
    check("norev_hx", head_x, 350);
    restart_right();
    apply(0, 0, 0, LEFT, PL, 0, 0);
    apply(0, 1, 0, 0, PL, 0, 0);
    check("rev_hx", head_x, 310);

    // Right wall.
    restart_right();
    for (int i = 0; i < 31; i++) apply(0, 1, 0, 0, PL, 0, 0);
    check("rwall_pre_hx", head_x, 630);
    apply(0, 1, 0, 0, PL, 0, 0);
    check("rwall_hit", wall_hit, 1);
    check("rwall_hx", head_x, 630);
    apply(0, 0, 0, 0, PL, 0, 0);
    check("rwall_pulse", wall_hit, 0);

    // Left wall.
    apply(1, 0, 0, 0, 0, 0, 0);
    apply(0, 0, 0, LEFT, PL, 0, 0);
    for (int i = 0; i < 32; i++) apply(0, 1, 0, 0, PL, 0, 0);
    check("lwall_pre_hx", head_x, 0);
    apply(0, 1, 0, 0, PL, 0, 0);
    check("lwall_hit", wall_hit, 1);
    check("lwall_hx", head_x, 0);

    // Update outside PLAY is ignored.
    restart_right();
    apply(0, 1, 0, 0, 0, 0, 0);
    check("hold_hx", head_x, 320);

    // Self collision: length 4, then UP, LEFT, DOWN back into the body.
    restart_right();
    for (int i = 0; i < 4; i++) apply(0, 1, 1, 0, PL, 0, 0);
    apply(0, 0, 0, UP, PL, 0, 0);   apply(0, 1, 0, 0, PL, 0, 0);
    check("self_up", self_hit, 0);
    apply(0, 0, 0, LEFT, PL, 0, 0); apply(0, 1, 0, 0, PL, 0, 0);
    check("self_left", self_hit, 0);
    apply(0, 0, 0, DOWN, PL, 0, 0); apply(0, 1, 0, 0, PL, 0, 0);
    check("self_hit", self_hit, 1);
    apply(0, 0, 0, 0, PL, 0, 0);
    check("self_pulse", self_hit, 0);

    // GAME_OVER restores reset values and blanks pixels.
    apply(0, 0, 0, 0, GO, m_hx + 5, m_hy + 5);
    check("go_hx", head_x, 320);
    check("go_hy", head_y, 240);
    check("go_len", length, 0);
    check("go_head_px", head_active, 0);
    apply(0, 1, 0, 0, PL, 325, 245);
    check("go_idle_hx", head_x, 320);

    // Randomized run against the model.
    apply(1, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 4000; n++) begin
      int r, gs, dir, sel, k, px, py;
      r = $urandom_range(0, 199);
      gs = (r < 185) ? PL : (r < 195) ? 0 : (r < 197) ? 2 : GO;
      dir = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 4));
      sel = $urandom_range(0, 9);
      if (sel < 4) begin
        px = m_hx + int'($urandom_range(0, CELL)); py = m_hy + int'($urandom_range(0, CELL));
      end else if (sel < 8 && body.size() > 0) begin
        k = $urandom_range(0, body.size() - 1);
        px = body[k].x + int'($urandom_range(0, CELL)); py = body[k].y + int'($urandom_range(0, CELL));
      end else begin
        px = $urandom_range(0, 1023); py = $urandom_range(0, 1023);
      end
      apply($urandom_range(0, 499) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
            dir, gs, px, py);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
